alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. One operation is taken
// at a time, round-robin between the requesters. The accepted operands are
// registered and driven to the ALU for one cycle. The ALU result is then
// captured and returned with the winning requester's ID on a response channel
// that can be backpressured.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holds valid and its payload
// stable until that edge. ready never depends on the same channel's payload,
// only on valid and on arbiter state.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_valid/a/b/op, ready   requester 0 operation channel
//   req1_valid/a/b/op, ready   requester 1 operation channel
//   alu_a, alu_b, alu_op       registered operands to the shared ALU
//   alu_y                      ALU result, combinational from alu_a/b/op
//   rsp_valid, rsp_ready       response channel handshake
//   rsp_y, rsp_id              captured result and issuing requester
//   busy                       high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int WIDTH = 4,
   parameter int OPW   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic             req1_ready,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_y,
   output logic             rsp_id,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   logic             rr_ptr;   // requester that wins when both are valid
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic [OPW-1:0]   op_q;
   logic             grant0;
   logic             grant1;
   logic             take0;
   logic             take1;

   // A lone valid always wins. When both are valid, rr_ptr picks the winner.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | ~rr_ptr);
      grant1 = req1_valid & (~req0_valid |  rr_ptr);
   end

   // Readies are offered only in IDLE. They are gated by rst_n so that
   // nothing looks accepted while reset is asserted.
   assign req0_ready = rst_n & (state == IDLE) & grant0;
   assign req1_ready = rst_n & (state == IDLE) & grant1;
   assign take0      = req0_valid & req0_ready;
   assign take1      = req1_valid & req1_ready;

   // The ALU always sees the operand registers. They only change on an
   // accept, so they stay stable through EXEC and RESP.
   assign alu_a  = opa_q;
   assign alu_b  = opb_q;
   assign alu_op = op_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         opa_q     <= '0;
         opb_q     <= '0;
         op_q      <= '0;
         rsp_y     <= '0;
         rsp_id    <= 1'b0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take0 || take1) begin
                  opa_q  <= take1 ? req1_a  : req0_a;
                  opb_q  <= take1 ? req1_b  : req0_b;
                  op_q   <= take1 ? req1_op : req0_op;
                  rsp_id <= take1;
                  // The loser of this grant gets priority on the next tie.
                  rr_ptr <= ~take1;
                  busy   <= 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               // The operands have been stable on the ALU for a whole cycle.
               rsp_y     <= alu_y;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Bench for alu_arbiter. A small combinational ALU stands in for the shared
// ALU. The reference model works at the operation level. It tracks which
// requester was served last, which operations are pending, and the result
// arithmetic modulo 2^WIDTH. Expected responses are queued in exp_q.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
   localparam int WIDTH = 4;
   localparam int OPW   = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [OPW-1:0]   req0_op;
   logic             req0_ready;
   logic             req1_valid;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [OPW-1:0]   req1_op;
   logic             req1_ready;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_y;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_y;
   logic             rsp_id;
   logic             busy;

   int total = 0;
   int bad   = 0;

   // model state
   logic [WIDTH:0]   exp_q[$];   // {id, result}
   int               last_id;    // requester served most recently
   bit               pend[2];
   logic [WIDTH-1:0] pa[2];
   logic [WIDTH-1:0] pb[2];
   logic [OPW-1:0]   po[2];

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
      .req0_op(req0_op), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
      .req1_op(req1_op), .req1_ready(req1_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_y(rsp_y), .rsp_id(rsp_id), .busy(busy)
   );

   // shared ALU stand-in
   always_comb begin
      case (alu_op)
         2'd0:    alu_y = alu_a + alu_b;
         2'd1:    alu_y = alu_a - alu_b;
         2'd2:    alu_y = alu_a & alu_b;
         default: alu_y = alu_a | alu_b;
      endcase
   end

   // ---------------- reference model ----------------
   function automatic logic [WIDTH-1:0] alu_ref(int a, int b, int op);
      int m;
      int r;
      m = 1 << WIDTH;
      case (op)
         0:       r = (a + b) % m;
         1:       r = (a - b + m) % m;
         2:       r = a & b;
         default: r = a | b;
      endcase
      return WIDTH'(r);
   endfunction

   // The requester not served last wins a tie.
   function automatic int pick(bit v0, bit v1);
      if (v0 && !v1) return 0;
      if (v1 && !v0) return 1;
      return (last_id == 0) ? 1 : 0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
   endtask

   task automatic apply_pending();
      req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = po[0];
      req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = po[1];
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      last_id = 1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd3; req0_op = 2'd0;
      req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd2; req1_op = 2'd1;
      tick();
      total++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         bad++; $display("FAIL reset_readies actual=%b expected=00", {req0_ready, req1_ready});
      end
      total++;
      if ({rsp_valid, busy, rsp_id} !== 3'b000) begin
         bad++; $display("FAIL reset_ctrl actual=%b expected=000", {rsp_valid, busy, rsp_id});
      end
      total++;
      if (rsp_y !== 4'd0) begin
         bad++; $display("FAIL reset_rsp_y actual=%0d expected=0", rsp_y);
      end
      total++;
      if ({alu_a, alu_b, alu_op} !== 10'd0) begin
         bad++; $display("FAIL reset_alu actual=%0h expected=0", {alu_a, alu_b, alu_op});
      end
      idle_inputs();
      tick();
      rst_n = 1'b1;
      last_id = 1;
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd2; req0_op = 2'd0;
      rsp_ready = 1'b1;
      @(negedge clk);
      total++;
      if ({req0_ready, req1_ready, busy} !== 3'b100) begin
         bad++; $display("FAIL single_ready actual=%b expected=100", {req0_ready, req1_ready, busy});
      end
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b1000) begin
         bad++; $display("FAIL single_exec_ctrl actual=%b expected=1000", {busy, rsp_valid, req0_ready, req1_ready});
      end
      total++;
      if ({alu_a, alu_b, alu_op} !== {4'd3, 4'd2, 2'd0}) begin
         bad++; $display("FAIL single_alu_drive actual=%0h expected=%0h", {alu_a, alu_b, alu_op}, {4'd3, 4'd2, 2'd0});
      end
      tick();
      @(negedge clk);
      total++;
      if ({rsp_valid, busy, rsp_id, rsp_y} !== {1'b1, 1'b1, 1'b0, 4'd5}) begin
         bad++; $display("FAIL single_rsp actual=%b expected=%b", {rsp_valid, busy, rsp_id, rsp_y}, {1'b1, 1'b1, 1'b0, 4'd5});
      end
      tick();
      @(negedge clk);
      total++;
      if ({rsp_valid, busy} !== 2'b00) begin
         bad++; $display("FAIL single_done actual=%b expected=00", {rsp_valid, busy});
      end
      tick();
      last_id = 0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd1; req0_op = 2'd1;
      req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd3; req1_op = 2'd2;
      @(negedge clk);
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         bad++; $display("FAIL simul_grant0 actual=%b expected=10", {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         bad++; $display("FAIL simul_exec_hold actual=%b expected=00", {req0_ready, req1_ready});
      end
      tick();
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, alu_ref(7, 1, 1)}) begin
         bad++; $display("FAIL simul_rsp0 actual=%b expected=%b", {rsp_valid, rsp_id, rsp_y}, {1'b1, 1'b0, alu_ref(7, 1, 1)});
      end
      tick();
      @(negedge clk);
      total++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         bad++; $display("FAIL simul_grant1 actual=%b expected=01", {req0_ready, req1_ready});
      end
      tick();
      req1_valid = 1'b0;
      tick();
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b1, 4'd1}) begin
         bad++; $display("FAIL simul_rsp1 actual=%b expected=%b", {rsp_valid, rsp_id, rsp_y}, {1'b1, 1'b1, 4'd1});
      end
      tick();
      last_id = 1;
   endtask

   task automatic test_fairness();
      logic [WIDTH-1:0] fa[2];
      logic [WIDTH-1:0] fb[2];
      logic [OPW-1:0]   fo[2];
      int               exp_id;
      for (int r = 0; r < 2; r++) begin
         fa[r] = WIDTH'($urandom_range(0, 15));
         fb[r] = WIDTH'($urandom_range(0, 15));
         fo[r] = OPW'($urandom_range(0, 3));
      end
      req0_valid = 1'b1; req0_a = fa[0]; req0_b = fb[0]; req0_op = fo[0];
      req1_valid = 1'b1; req1_a = fa[1]; req1_b = fb[1]; req1_op = fo[1];
      rsp_ready = 1'b1;
      // one operation per 3 cycles: accept, execute, respond
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         exp_id = (last_id == 0) ? 1 : 0;
         total++;
         if (c % 3 == 0) begin
            if ({req0_ready, req1_ready} !== ((exp_id == 0) ? 2'b10 : 2'b01)) begin
               bad++; $display("FAIL fair_grant cycle=%0d actual=%b expected_id=%0d", c, {req0_ready, req1_ready}, exp_id);
            end
         end else if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++; $display("FAIL fair_no_ready cycle=%0d actual=%b expected=00", c, {req0_ready, req1_ready});
         end
         total++;
         if (rsp_valid !== (c % 3 == 2)) begin
            bad++; $display("FAIL fair_rsp_valid cycle=%0d actual=%b expected=%b", c, rsp_valid, (c % 3 == 2));
         end
         if (c % 3 == 2) begin
            total++;
            if ({rsp_id, rsp_y} !== {exp_id[0], alu_ref(int'(fa[exp_id]), int'(fb[exp_id]), int'(fo[exp_id]))}) begin
               bad++; $display("FAIL fair_rsp cycle=%0d actual=%b expected_id=%0d", c, {rsp_id, rsp_y}, exp_id);
            end
            last_id = exp_id;
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd6; req1_op = 2'd3;
      @(negedge clk);
      total++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         bad++; $display("FAIL bp_grant actual=%b expected=01", {req0_ready, req1_ready});
      end
      tick();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; req0_op = 2'd0;
      tick();
      for (int s = 0; s < 4; s++) begin
         rsp_ready = (s == 3);
         @(negedge clk);
         total++;
         if ({rsp_valid, rsp_id, rsp_y, req0_ready, req1_ready} !== {1'b1, 1'b1, 4'd15, 2'b00}) begin
            bad++; $display("FAIL bp_hold step=%0d actual=%b expected=%b", s, {rsp_valid, rsp_id, rsp_y, req0_ready, req1_ready}, {1'b1, 1'b1, 4'd15, 2'b00});
         end
         tick();
      end
      @(negedge clk);
      total++;
      if ({rsp_valid, req0_ready} !== 2'b01) begin
         bad++; $display("FAIL bp_release actual=%b expected=01", {rsp_valid, req0_ready});
      end
      tick();
      req0_valid = 1'b0;
      tick();
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, 4'd5}) begin
         bad++; $display("FAIL bp_second actual=%b expected=%b", {rsp_valid, rsp_id, rsp_y}, {1'b1, 1'b0, 4'd5});
      end
      tick();
      last_id = 0;
   endtask

   task automatic test_wrap();
      logic [WIDTH-1:0] ta[3];
      logic [WIDTH-1:0] tb[3];
      logic [OPW-1:0]   top[3];
      logic [WIDTH-1:0] ty[3];
      ta  = '{4'd9, 4'd1, 4'd12};
      tb  = '{4'd9, 4'd2, 4'd10};
      top = '{2'd0, 2'd1, 2'd2};
      ty  = '{4'd2, 4'd15, 4'd8};
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req0_valid = 1'b1; req0_a = ta[i]; req0_b = tb[i]; req0_op = top[i];
         tick();
         req0_valid = 1'b0;
         tick();
         @(negedge clk);
         total++;
         if ({rsp_valid, rsp_y} !== {1'b1, ty[i]}) begin
            bad++; $display("FAIL wrap_%0d actual_valid=%b actual_y=%0d expected_y=%0d", i, rsp_valid, rsp_y, ty[i]);
         end
         tick();
      end
      last_id = 0;
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd5; req0_op = 2'd0;
      tick();
      req0_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({alu_a, alu_b, alu_op, rsp_y} !== 14'd0) begin
         bad++; $display("FAIL rmid_data_clear actual=%0h expected=0", {alu_a, alu_b, alu_op, rsp_y});
      end
      total++;
      if ({rsp_valid, busy, rsp_id, req0_ready, req1_ready} !== 5'd0) begin
         bad++; $display("FAIL rmid_ctrl_clear actual=%b expected=00000", {rsp_valid, busy, rsp_id, req0_ready, req1_ready});
      end
      req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_op = 2'd0;
      req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2; req1_op = 2'd0;
      tick();
      total++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
         bad++; $display("FAIL rmid_held actual=%b expected=000", {rsp_valid, req0_ready, req1_ready});
      end
      rst_n = 1'b1;
      last_id = 1;
      @(negedge clk);
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         bad++; $display("FAIL rmid_grant0 actual=%b expected=10", {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 1'b0;
      tick();
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, 4'd2}) begin
         bad++; $display("FAIL rmid_rsp0 actual=%b expected=%b", {rsp_valid, rsp_id, rsp_y}, {1'b1, 1'b0, 4'd2});
      end
      tick();
      @(negedge clk);
      total++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         bad++; $display("FAIL rmid_grant1 actual=%b expected=01", {req0_ready, req1_ready});
      end
      tick();
      req1_valid = 1'b0;
      tick();
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b1, 4'd4}) begin
         bad++; $display("FAIL rmid_rsp1 actual=%b expected=%b", {rsp_valid, rsp_id, rsp_y}, {1'b1, 1'b1, 4'd4});
      end
      tick();
   endtask

   task automatic test_random(input int n_ops);
      int               done;
      int               guard;
      int               w;
      int               stall;
      logic [WIDTH-1:0] ea;
      logic [WIDTH-1:0] eb;
      logic [OPW-1:0]   eo;
      logic [WIDTH:0]   e;
      done  = 0;
      guard = 0;
      do_reset();
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      exp_q.delete();
      while (done < n_ops && guard < 2000) begin
         guard++;
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && $urandom_range(0, 3) != 0) begin
               pend[r] = 1'b1;
               pa[r] = WIDTH'($urandom_range(0, 15));
               pb[r] = WIDTH'($urandom_range(0, 15));
               po[r] = OPW'($urandom_range(0, 3));
            end
         end
         // rsp_ready has no effect while no response is offered
         rsp_ready = 1'($urandom_range(0, 1));
         apply_pending();
         @(negedge clk);
         if (!pend[0] && !pend[1]) begin
            total++;
            if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0000) begin
               bad++; $display("FAIL rand_idle actual=%b expected=0000", {req0_ready, req1_ready, busy, rsp_valid});
            end
            tick();
            continue;
         end
         w = pick(pend[0], pend[1]);
         total++;
         if ({req0_ready, req1_ready, busy} !== ((w == 0) ? 3'b100 : 3'b010)) begin
            bad++; $display("FAIL rand_grant op=%0d actual=%b expected_id=%0d", done, {req0_ready, req1_ready, busy}, w);
         end
         tick();
         ea = pa[w]; eb = pb[w]; eo = po[w];
         exp_q.push_back({w[0], alu_ref(int'(ea), int'(eb), int'(eo))});
         last_id = w;
         pend[w] = 1'b0;
         // the winner may post its next op at once; it has to wait
         if ($urandom_range(0, 1) == 1) begin
            pend[w] = 1'b1;
            pa[w] = WIDTH'($urandom_range(0, 15));
            pb[w] = WIDTH'($urandom_range(0, 15));
            po[w] = OPW'($urandom_range(0, 3));
         end
         apply_pending();
         rsp_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         total++;
         if ({busy, rsp_valid, req0_ready, req1_ready, alu_a, alu_b, alu_op} !== {4'b1000, ea, eb, eo}) begin
            bad++; $display("FAIL rand_exec op=%0d actual=%b expected=%b", done, {busy, rsp_valid, req0_ready, req1_ready, alu_a, alu_b, alu_op}, {4'b1000, ea, eb, eo});
         end
         tick();
         stall = $urandom_range(0, 3);
         for (int s = 0; s <= stall; s++) begin
            rsp_ready = (s == stall);
            @(negedge clk);
            total++;
            if ({rsp_valid, req0_ready, req1_ready, rsp_id, rsp_y} !== {3'b100, exp_q[0]}) begin
               bad++; $display("FAIL rand_rsp op=%0d step=%0d actual=%b expected=%b", done, s, {rsp_valid, req0_ready, req1_ready, rsp_id, rsp_y}, {3'b100, exp_q[0]});
            end
            tick();
         end
         e = exp_q.pop_front();
         done++;
      end
      total++;
      if (done != n_ops || exp_q.size() != 0) begin
         bad++; $display("FAIL rand_complete actual=%0d expected=%0d", done, n_ops);
      end
      idle_inputs();
      rsp_ready = 1'b1;
      tick();
   endtask

   // ---------------- sequence ----------------
   initial begin
      idle_inputs();
      rsp_ready = 1'b0;
      last_id = 1;
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_random(40);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
